// File: rtl/char_norm_pkg.sv
// -----------------------------------------------------------------------------
// char_norm_pkg
// Shared types and constants for the character normalizer front-end.
//   - norm_state_e : normalizer FSM states (CMNT only reachable when the
//                    NORM_LINE_COMMENT_EN macro is defined)
//   - char_class_e : byte classification (BAD / SEP / WORD)
//   - character constants and printable-range bounds
//   - classify()   : byte -> class
//   - to_lower()   : folds 'A'..'Z' to lower case, other bytes unchanged
// -----------------------------------------------------------------------------
package char_norm_pkg;

    typedef enum logic [2:0] {
        LEAD = 3'd0,   // stream start, skipping separators
        WORD = 3'd1,   // inside a word
        SEP  = 3'd2,   // one space already emitted after a word
        PAD  = 3'd3,   // terminating space still owed
        CMNT = 3'd4    // inside a line comment
    } norm_state_e;

    typedef enum logic [1:0] {
        CLS_BAD  = 2'd0,
        CLS_SEP  = 2'd1,
        CLS_WORD = 2'd2
    } char_class_e;

    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_TAB      = 8'h09;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_HASH     = 8'h23;
    localparam logic [7:0] CH_UA       = 8'h41;
    localparam logic [7:0] CH_UZ       = 8'h5A;
    localparam logic [7:0] CH_CASE_OFS = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h21;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    function automatic char_class_e classify(input logic [7:0] c);
        char_class_e cls;
        if (c == CH_SPACE || c == CH_TAB || c == CH_LF || c == CH_CR) begin
            cls = CLS_SEP;
        end else if (c >= CH_PRINT_LO && c <= CH_PRINT_HI) begin
            cls = CLS_WORD;
        end else begin
            cls = CLS_BAD;
        end
        return cls;
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        logic [7:0] r;
        if (c >= CH_UA && c <= CH_UZ) begin
            r = c + CH_CASE_OFS;
        end else begin
            r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/char_normalizer_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO holding {last, char} entries for the normalizer output.
// Pointers carry one extra wrap bit: empty when equal, full when the wrap
// bits differ and the index bits match. The head entry is presented
// directly from the storage array so a pushed entry is visible one cycle
// after the write; the head reads as zero while empty.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset (pointers only)
//   push_i       : write push_data_i (ignored when full)
//   push_data_i  : WIDTH-bit entry
//   pop_i        : consume head (ignored when empty)
//   head_o       : current head entry (zero when empty)
//   full_o       : no free entry
//   empty_o      : no valid entry
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_o = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/char_normalizer.sv
// -----------------------------------------------------------------------------
// char_normalizer
// Cleans a raw ASCII stream for the begin/end block checker: lower-cases
// letters, collapses whitespace runs into one space, drops leading
// whitespace and non-printable bytes, and guarantees every stream ends with
// a space flagged out_last. Results are queued in a DEPTH-entry FIFO.
// Optional build macro: NORM_LINE_COMMENT_EN -- '#' opens a line comment that
// is swallowed up to the next LF, which then acts as a separator.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake; in_char raw byte, in_last ends stream
//   out_valid/out_ready  : output handshake; out_char normalized byte,
//                          out_last marks the stream's terminating space
//   word_count           : words started since reset (saturating)
//   drop_count           : non-printable bytes dropped (saturating)
// -----------------------------------------------------------------------------
module char_normalizer
    import char_norm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_char,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_char,
    output logic             out_last,
    output logic [CNT_W-1:0] word_count,
    output logic [CNT_W-1:0] drop_count
);

    norm_state_e      state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`ifdef NORM_LINE_COMMENT_EN
    norm_state_e      saved_q, saved_d;
`endif

    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_head;
    logic             push;
    logic [7:0]       push_char;
    logic             push_last;
    logic             accept;
    logic             word_inc;
    logic             drop_inc;
    logic             take_normal;
    norm_state_e      base_state;
    char_class_e      base_cls;
    char_class_e      in_cls;
    logic [7:0]       in_lower;

    // Held low during reset so nothing is accepted while the FIFO is cleared.
    assign in_ready = !reset && !fifo_full && (state_q != PAD);
    assign accept   = in_valid && in_ready;
    assign in_cls   = classify(in_char);
    assign in_lower = to_lower(in_char);

    always_comb begin
        state_d     = state_q;
        push        = 1'b0;
        push_char   = CH_SPACE;
        push_last   = 1'b0;
        word_inc    = 1'b0;
        drop_inc    = 1'b0;
        base_state  = state_q;
        base_cls    = in_cls;
        take_normal = accept;
`ifdef NORM_LINE_COMMENT_EN
        saved_d     = saved_q;
        if (accept && state_q == CMNT) begin
            if (in_char == CH_LF) begin
                // Comment ends: the LF acts as a separator seen from the
                // state that was active before the '#'.
                base_state = saved_q;
                base_cls   = CLS_SEP;
            end else if (in_last) begin
                base_cls = CLS_SEP;
            end else begin
                take_normal = 1'b0;
            end
        end else if (accept && in_char == CH_HASH) begin
            if (in_last) begin
                base_cls = CLS_SEP;
            end else begin
                take_normal = 1'b0;
                saved_d     = state_q;
                state_d     = CMNT;
            end
        end
`endif

        if (state_q == PAD) begin
            if (!fifo_full) begin
                push      = 1'b1;
                push_char = CH_SPACE;
                push_last = 1'b1;
                state_d   = LEAD;
            end
        end else if (take_normal) begin
            unique case (base_cls)
                CLS_BAD: begin
                    drop_inc = 1'b1;
                    if (in_last) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                        state_d   = LEAD;
                    end
                end
                CLS_SEP: begin
                    if (in_last) begin
                        push      = 1'b1;
                        push_last = 1'b1;
                        state_d   = LEAD;
                    end else if (base_state == WORD) begin
                        push    = 1'b1;
                        state_d = SEP;
                    end else begin
                        state_d = base_state;
                    end
                end
                CLS_WORD: begin
                    push      = 1'b1;
                    push_char = in_lower;
                    word_inc  = (base_state != WORD);
                    // A final word byte still owes the terminating space.
                    state_d   = in_last ? PAD : WORD;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (word_inc && word_cnt_q != {CNT_W{1'b1}}) begin
            word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (drop_inc && drop_cnt_q != {CNT_W{1'b1}}) begin
            drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LEAD;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef NORM_LINE_COMMENT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saved_q <= LEAD;
        end else begin
            saved_q <= saved_d;
        end
    end
`endif

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({push_last, push_char}),
        .pop_i       (out_ready),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_last   = fifo_head[8];
    assign out_char   = fifo_head[7:0];
    assign word_count = word_cnt_q;
    assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_char_normalizer.sv
module tb_char_normalizer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_char;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_char;
    logic             out_last;
    logic [CNT_W-1:0] word_count;
    logic [CNT_W-1:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q [$];
    int m_state = 0;   // 0 lead, 1 word, 2 sep
    int m_words = 0;
    int m_drops = 0;

    always #5 clk = ~clk;

    char_normalizer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_char    (in_char),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_char   (out_char),
        .out_last   (out_last),
        .word_count (word_count),
        .drop_count (drop_count)
    );

    task automatic check_val(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Reference behaviour of one accepted byte: queue the bytes it must emit.
    function automatic void model_accept(input logic [7:0] c, input logic last);
        bit         is_sep;
        bit         is_word;
        logic [7:0] lc;
        is_sep  = (c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D);
        is_word = (c >= 8'h21 && c <= 8'h7E);
        lc      = (c >= 8'h41 && c <= 8'h5A) ? c + 8'h20 : c;
        if (is_word) begin
            if (m_state != 1) m_words++;
            exp_q.push_back({1'b0, lc});
            if (last) begin
                exp_q.push_back({1'b1, 8'h20});
                m_state = 0;
            end else begin
                m_state = 1;
            end
        end else if (!is_sep) begin
            m_drops++;
            if (last) begin
                exp_q.push_back({1'b1, 8'h20});
                m_state = 0;
            end
        end else begin
            if (last) begin
                exp_q.push_back({1'b1, 8'h20});
                m_state = 0;
            end else if (m_state == 1) begin
                exp_q.push_back({1'b0, 8'h20});
                m_state = 2;
            end
        end
    endfunction

    // Output monitor: every consumed head is compared with the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out", exp_q.size(), 1);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                $display("out char=%02h last=%b (exp %02h/%b)", out_char, out_last, e[7:0], e[8]);
                check_val("out_byte", {23'd0, out_last, out_char}, {23'd0, e});
            end
        end
    end

    task automatic send(input logic [7:0] c, input logic last);
        int waited;
        bit done;
        waited = 0;
        done   = 0;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                model_accept(c, last);
                $display("in  char=%02h last=%b", c, last);
                done = 1;
            end else if (++waited > 200) begin
                check_val("in_ready_timeout", {31'd0, in_ready}, 1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input bit last_at_end);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], last_at_end && (i == s.len() - 1));
        end
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || out_valid) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 0);
        check_val("rst_out_char", {24'd0, out_char}, 0);
        check_val("rst_out_last", {31'd0, out_last}, 0);
        check_val("rst_word_count", word_count, 0);
        check_val("rst_drop_count", drop_count, 0);
        check_val("rst_in_ready", {31'd0, in_ready}, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("in_ready_after_rst", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Case folding, leading whitespace, tab separator, final pad space.
        send_str("  BeGiN\tEND", 1);
        drain("drain_t1");
        check_val("t1_word_count", word_count, 2);
        check_val("t1_model_words", word_count, m_words);

        // Separator run collapses to one space.
        send_str("a \t\n b", 1);
        drain("drain_t2");
        check_val("t2_drop_count", drop_count, 0);
        check_val("t2_word_count", word_count, 4);

        // Non-printable bytes dropped and counted.
        send(8'h78, 0);
        send(8'h01, 0);
        send(8'h7F, 0);
        send(8'hC3, 0);
        send(8'h79, 0);
        send(8'h20, 1);
        drain("drain_t3");
        check_val("t3_drop_count", drop_count, 3);
        check_val("t3_word_count", word_count, m_words);

        // Back-pressure: four entries fill the FIFO and stall the input.
        out_ready = 1'b0;
        send_str("abcd", 0);
        @(negedge clk);
        check_val("t4_in_ready_full", {31'd0, in_ready}, 0);
        check_val("t4_out_valid", {31'd0, out_valid}, 1);
        check_val("t4_head_hold0", {24'd0, out_char}, 32'h61);
        @(negedge clk);
        check_val("t4_head_hold1", {24'd0, out_char}, 32'h61);
        check_val("t4_last_hold", {31'd0, out_last}, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_str("ef", 0);
        send(8'h20, 1);
        drain("drain_t4");

        // in_last on a separator while already in SEP: one extra last space.
        send_str("ab  ", 1);
        drain("drain_t5");
        send_str("  z", 1);
        drain("drain_t5b");
        check_val("t5_word_count", word_count, m_words);

        // Reset with entries queued.
        out_ready = 1'b0;
        send_str("pqr", 0);
        @(negedge clk);
        check_val("t6_queued", {31'd0, out_valid}, 1);
        reset = 1'b1;
        #1;
        check_val("t6_rst_out_valid", {31'd0, out_valid}, 0);
        check_val("t6_rst_word_count", word_count, 0);
        check_val("t6_rst_drop_count", drop_count, 0);
        check_val("t6_rst_in_ready", {31'd0, in_ready}, 0);
        exp_q.delete();
        m_state = 0;
        m_words = 0;
        m_drops = 0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        send_str("  hi", 1);
        drain("drain_t6");
        check_val("t6_word_count", word_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/char_normalizer.md
Name: char_normalizer

Overview:
- Upstream front-end of the begin/end block checker; sits between the raw character source and the checker's 8-bit per-cycle input.
- Cleans a raw ASCII stream:
  - lower-cases letters
  - maps all whitespace to a single space and collapses runs
  - drops leading whitespace and non-printable bytes
  - guarantees the stream ends with a space, so the checker commits the final word.
- Output is buffered in a small FIFO with valid/ready on both sides.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, >= 2.
- CNT_W, 16, width of word_count and drop_count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_char/in_last valid
- in_ready  out  1  normalizer accepts this cycle
- in_char  in  8  raw ASCII byte
- in_last  in  1  final byte of current stream
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream consumes head
- out_char  out  8  normalized byte
- out_last  out  1  head is final byte of stream (always a space)
- word_count  out  CNT_W  words started since reset, saturating
- drop_count  out  CNT_W  bytes dropped as non-printable, saturating

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state LEAD
  - FIFO empty; out_valid=0, out_char=0, out_last=0
  - counters 0
  - in_ready=0 while reset is asserted, 1 on the first cycle after release.
- Accept: in_valid && in_ready. in_ready = !fifo_full && state!=PAD.
- Byte classes:
  - SEP: 0x20, 0x09, 0x0A, 0x0D.
  - WORD: 0x21–0x7E; 'A'–'Z' are mapped to +0x20.
  - BAD: everything else. BAD is dropped, drop_count++, and causes no state change.
- States: LEAD (stream start, skipping separators), WORD (inside a word), SEP (space already emitted), PAD (owe a terminating space).
- Transitions on accept with in_last=0:
  - LEAD: WORD byte -> push char, word_count++, ->WORD. SEP or BAD -> push nothing, stay.
  - WORD: WORD -> push char. SEP -> push 0x20, ->SEP.
  - SEP: SEP -> push nothing. WORD -> push char, word_count++, ->WORD.
- Accept with in_last=1:
  - WORD byte: push char (out_last=0), plus word_count++ if coming from LEAD/SEP; ->PAD.
  - SEP or BAD byte (any state): push 0x20 with out_last=1; ->LEAD. This single trailing space is the one permitted exception to collapsing; it guarantees every stream carries an out_last.
- PAD: when !fifo_full, push 0x20 with out_last=1, ->LEAD. Input is stalled while in PAD.
- FIFO:
  - read/write pointers log2(DEPTH)+1 bits; full when MSBs differ and lower bits are equal.
  - Simultaneous push and pop are legal whenever not full.
  - No combinational in->out bypass; minimum latency is 1 cycle from accept to out_valid.
  - out_char/out_last hold steady while out_valid && !out_ready.
- Counters saturate at all-ones and never wrap.
- Reset mid-stream discards FIFO contents and partial state; no out_last is emitted for the aborted stream.

Optional Feature:
- Macro: NORM_LINE_COMMENT_EN.
- Defined:
  - '#' (0x23) in any non-PAD state enters state CMNT.
  - In CMNT, every byte is dropped without counting until 0x0A. The 0x0A is then treated as SEP from the state saved before '#'.
  - in_last in CMNT follows the SEP/BAD in_last rule.
- Undefined: '#' is an ordinary WORD byte and CMNT does not exist.

Decomposition:
- Package char_norm_pkg holds:
  - state enum (LEAD, WORD, SEP, PAD, CMNT)
  - character constants: CH_SPACE, CH_TAB, CH_LF, CH_CR, CH_HASH, CH_UA, CH_UZ, CH_CASE_OFS=0x20
  - printable bounds 0x21/0x7E.
- Sub-module sync_fifo (parameters WIDTH=9, DEPTH) holds {last,char}; all classification and the FSM stay in char_normalizer.

Test Plan:
- "  BeGiN\tEND" + in_last on 'D', out_ready=1 -> out "begin end " with out_last only on the final 0x20; word_count=2.
- "a \t\n b" in_last on 'b' -> out "a b " (one separator space, one pad space); drop_count=0.
- Bytes 0x01, 0x7F, 0xC3 inside "x?y" -> dropped; output "xy"-equivalent stream; drop_count=3.
- Hold out_ready=0 and feed 6 WORD bytes, DEPTH=4 -> in_ready=0 after 4 accepts; no loss when out_ready is released; order preserved.
- Stream with in_last on a SEP while in SEP state -> exactly one extra 0x20 with out_last=1; state returns to LEAD.
- Assert reset with 3 entries queued -> out_valid=0 immediately; counters 0; next stream's leading spaces are skipped.
